// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants and elaboration-time helpers for the Keccak
// iota stage.
//   lane_log2(w)       - log2 of a legal lane width (8..64)
//   rc_lfsr_step(s)    - one step of the rc(t) LFSR: next state + output bit
//   rc_seed(ir0)       - LFSR state at t = 7*ir0 (the first-round seed)
//   lane00_lsb(w)      - bit offset of lane (0,0) inside a 25*w state
package keccak_pkg;

  localparam int unsigned MAX_ROUNDS = 24;

  typedef struct packed {
    logic [7:0] state;
    logic       rc;
  } rc_step_t;

  function automatic int unsigned lane_log2(input int unsigned w);
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      if ((32'd1 << i) <= w) l = i;
    end
    return l;
  endfunction

  // rc(t) is bit 0 of the current state; polynomial x^8+x^6+x^5+x^4+1.
  function automatic rc_step_t rc_lfsr_step(input logic [7:0] s);
    rc_step_t r;
    r.rc    = s[0];
    r.state = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
    return r;
  endfunction

  function automatic logic [7:0] rc_seed(input int unsigned ir0);
    logic [7:0] s;
    rc_step_t   st;
    s = 8'h01;
    for (int unsigned t = 0; t < 7 * ir0; t++) begin
      st = rc_lfsr_step(s);
      s  = st.state;
    end
    return s;
  endfunction

  function automatic int unsigned lane00_lsb(input int unsigned w);
    return 24 * w;
  endfunction

endpackage

// File: rtl/keccak_rc_gen.sv
// keccak_rc_gen: round counter and round-constant generator.
//   clk, rst_n - clock, asynchronous active-low reset
//   advance    - consume the current round (counter and LFSR step)
//   restart    - force round IR0 / seed; also applies to a same-cycle advance
//   rc         - truncated round constant for the current round
//   round      - current round index ir
//   last       - current round is the final one of the permutation
//   busy       - registered counter is not at the first round
module keccak_rc_gen
  import keccak_pkg::*;
#(
  parameter int unsigned LANE_W     = 64,
  parameter int unsigned NUM_ROUNDS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              restart,
  output logic [LANE_W-1:0] rc,
  output logic [4:0]        round,
  output logic              last,
  output logic              busy
);

  localparam int unsigned L       = lane_log2(LANE_W);
  localparam int unsigned IR0     = 12 + 2 * L - NUM_ROUNDS;
  localparam int unsigned IR_LAST = IR0 + NUM_ROUNDS - 1;
  localparam logic [7:0]  SEED    = rc_seed(IR0);

  logic [4:0] ir_q;
  logic [7:0] lfsr_q;
  logic [4:0] ir_cur;
  logic [7:0] lfsr_cur;
  logic [7:0] lfsr_next;
  logic [6:0] rc_bits;

  // A restart is folded into the current view so that a coincident advance
  // already uses round IR0 and steps on from there.
  always_comb begin
    ir_cur   = restart ? 5'(IR0) : ir_q;
    lfsr_cur = restart ? SEED : lfsr_q;
  end

  // Seven LFSR steps per round: bit j of rc_bits is rc(7*ir + j).
  always_comb begin
    rc_step_t st;
    st        = '0;
    rc_bits   = '0;
    lfsr_next = lfsr_cur;
    for (int unsigned j = 0; j < 7; j++) begin
      st         = rc_lfsr_step(lfsr_next);
      rc_bits[j] = st.rc;
      lfsr_next  = st.state;
    end
  end

  always_comb begin
    rc = '0;
    for (int unsigned j = 0; j <= L; j++) begin
      rc[(1 << j) - 1] = rc_bits[j];
    end
  end

  assign round = ir_cur;
  assign last  = (ir_cur == 5'(IR_LAST));
  assign busy  = (ir_q != 5'(IR0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= 5'(IR0);
      lfsr_q <= SEED;
    end else if (advance) begin
      if (last) begin
        ir_q   <= 5'(IR0);
        lfsr_q <= SEED;
      end else begin
        ir_q   <= ir_cur + 5'd1;
        lfsr_q <= lfsr_next;
      end
    end else if (restart) begin
      ir_q   <= 5'(IR0);
      lfsr_q <= SEED;
    end
  end

endmodule

// File: rtl/keccak_iota_rc_stage.sv
// keccak_iota_rc_stage: registered, valid/ready iota step with internally
// generated round constants.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - restart the round sequence at the first round
//   in_valid / in_ready - input handshake for chi_in
//   chi_in              - chi output state, lane (0,0) in the top LANE_W bits
//   out_valid/out_ready - output handshake for iota_out
//   iota_out            - registered chi_in with RC XORed into lane (0,0)
//   out_round           - round index used for iota_out
//   out_last            - iota_out is the final round of the permutation
//   busy                - round counter is not at the first round
module keccak_iota_rc_stage
  import keccak_pkg::*;
#(
  parameter int unsigned LANE_W     = 64,
  parameter int unsigned NUM_ROUNDS = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [25*LANE_W-1:0]   chi_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [25*LANE_W-1:0]   iota_out,
  output logic [4:0]             out_round,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned SW  = 25 * LANE_W;
  localparam int unsigned LSB = lane00_lsb(LANE_W);

  logic              accept;
  logic [LANE_W-1:0] rc;
  logic [4:0]        round;
  logic              last;

  // Single-entry output register: accept whenever it is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  keccak_rc_gen #(
    .LANE_W    (LANE_W),
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_rc_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(accept),
    .restart(start),
    .rc     (rc),
    .round  (round),
    .last   (last),
    .busy   (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      iota_out  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      iota_out  <= {chi_in[SW-1:LSB] ^ rc, chi_in[LSB-1:0]};
      out_round <= round;
      out_last  <= last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
